// File: rtl/reg_bank_pkg.sv
// Shared processor constants for the register bank and the write-destination selector.
// Also provides the helper that turns a selector code into a destination index.
package reg_bank_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int SP_IDX   = 29;
    localparam int SP_RESET = 227;
    localparam int RA_IDX   = 31;

    // Write-destination choices: instruction rt field, rd field, stack pointer, return address.
    typedef enum logic [1:0] {
        WR_DST_RT = 2'd0,
        WR_DST_RD = 2'd1,
        WR_DST_SP = 2'd2,
        WR_DST_RA = 2'd3
    } wr_dst_e;

    function automatic logic [ADDR_W-1:0] wr_dst_idx(
        input wr_dst_e           sel,
        input logic [ADDR_W-1:0] rt,
        input logic [ADDR_W-1:0] rd
    );
        case (sel)
            WR_DST_RT: return rt;
            WR_DST_RD: return rd;
            WR_DST_SP: return ADDR_W'(SP_IDX);
            default:   return ADDR_W'(RA_IDX);
        endcase
    endfunction

endpackage

// File: rtl/reg_bank.sv
// Register bank with two asynchronous read ports and one synchronous write port.
// Register 0 is hard-wired to zero and the stack pointer has a non-zero reset value.
module reg_bank #(
    parameter int DATA_W   = reg_bank_pkg::DATA_W,
    parameter int ADDR_W   = reg_bank_pkg::ADDR_W,
    parameter int SP_IDX   = reg_bank_pkg::SP_IDX,
    parameter int SP_RESET = reg_bank_pkg::SP_RESET
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_wr_en;

    assign w_wr_en = reg_write && (write_reg != '0);

    // NOTE: the storage array is reset element by element because the stack pointer
    // needs a non-zero value straight out of reset; this keeps it in flops, not RAM.
    // NOTE: non-blocking assignments here so every read in the same edge sees old state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= (i == SP_IDX) ? DATA_W'(SP_RESET) : '0;
            end
        end else if (w_wr_en) begin
            r_regs[write_reg] <= write_data;
        end
    end

    // Reads show the stored value only; a same-cycle write is visible from the next cycle.
    // NOTE: each output gets a value on every path, so no latch can be inferred.
    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        if (read_reg1 != '0) read_data1 = r_regs[read_reg1];
        if (read_reg2 != '0) read_data2 = r_regs[read_reg2];
    end

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank: a shadow model feeds a scoreboard queue
// of expected read values that are popped and compared when the read port settles.
module tb_reg_bank;
    import reg_bank_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              reg_write;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;

    logic [DATA_W-1:0] model [2**ADDR_W];
    logic [DATA_W-1:0] sb_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    reg_bank dut (
        .clk        (clk),
        .reset      (reset),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 2**ADDR_W; i++) model[i] = '0;
        model[SP_IDX] = DATA_W'(SP_RESET);
    endtask

    task automatic compare(input string tag, input logic [DATA_W-1:0] obs);
        logic [DATA_W-1:0] exp;
        exp = sb_q.pop_front();
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Point one read port at idx, queue the model value, let it settle, then compare.
    task automatic check_read(input string tag, input int port, input logic [ADDR_W-1:0] idx);
        if (port == 1) read_reg1 = idx;
        else           read_reg2 = idx;
        sb_q.push_back(model[idx]);
        #1;
        compare(tag, (port == 1) ? read_data1 : read_data2);
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] idx, input logic [DATA_W-1:0] data);
        @(negedge clk);
        reg_write  = 1'b1;
        write_reg  = idx;
        write_data = data;
        @(posedge clk);
        if (idx != '0) model[idx] = data;
        #1;
        reg_write = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        reg_write  = 1'b0;
        write_reg  = '0;
        write_data = '0;
        read_reg1  = '0;
        read_reg2  = '0;

        // Reset asserted mid-cycle, all indices read on both ports.
        #3 reset = 1'b0;
        model_reset();
        for (int i = 0; i < 2**ADDR_W; i++) begin
            check_read($sformatf("reset_p1_r%0d", i), 1, ADDR_W'(i));
            check_read($sformatf("reset_p2_r%0d", i), 2, ADDR_W'(2**ADDR_W - 1 - i));
        end
        // Writes must be ignored while reset is held.
        @(negedge clk);
        reg_write = 1'b1; write_reg = 5'd8; write_data = 32'hCAFE_F00D;
        @(posedge clk); #1;
        reg_write = 1'b0;
        check_read("held_reset_r8", 1, 5'd8);
        @(negedge clk) reset = 1'b1;

        // Basic write/read.
        do_write(5'd8, 32'hDEAD_BEEF);
        check_read("wr_r8", 1, 5'd8);
        check_read("rd_r9", 2, 5'd9);
        check_read("both_ports_p2_r8", 2, 5'd8);
        compare_same: begin
            sb_q.push_back(32'hDEAD_BEEF);
            compare("both_ports_p1_r8", read_data1);
        end

        // Register 0 is immutable.
        do_write(5'd0, 32'h1234_5678);
        check_read("r0_zero", 1, 5'd0);

        // Same-cycle read of the written index: old value before the edge, new after.
        do_write(5'd5, 32'd1);
        @(negedge clk);
        reg_write = 1'b1; write_reg = 5'd5; write_data = 32'd7;
        check_read("r5_before_edge", 1, 5'd5);
        @(posedge clk);
        model[5] = 32'd7;
        #1;
        reg_write = 1'b0;
        check_read("r5_after_edge", 1, 5'd5);

        // Write enable off leaves R31 untouched.
        @(negedge clk);
        reg_write = 1'b0; write_reg = 5'(RA_IDX); write_data = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        check_read("we_off_r31", 1, 5'(RA_IDX));

        // SP and RA behave like ordinary registers.
        do_write(5'(SP_IDX), 32'h0000_0055);
        check_read("sp_write", 1, 5'(SP_IDX));
        do_write(5'(RA_IDX), 32'h8000_0001);
        check_read("ra_write", 2, 5'(RA_IDX));

        // Reset drops before the edge of a pending write to R29: reset value wins.
        @(negedge clk);
        reg_write = 1'b1; write_reg = 5'(SP_IDX); write_data = 32'd100;
        #2 reset = 1'b0;
        model_reset();
        check_read("rst_mid_wr_sp_now", 1, 5'(SP_IDX));
        check_read("rst_mid_wr_r8_now", 2, 5'd8);
        @(posedge clk); #1;
        check_read("rst_mid_wr_sp_edge", 1, 5'(SP_IDX));
        check_read("rst_mid_wr_r31_edge", 2, 5'(RA_IDX));
        reg_write = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check_read("post_rst_sp", 1, 5'(SP_IDX));
        check_read("post_rst_r5", 2, 5'd5);

        // Fresh write after reset release still works.
        do_write(5'd17, 32'hA5A5_5A5A);
        check_read("post_rst_wr_r17", 1, 5'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
